// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed byte stream, writes little-endian words to memory, then releases the core
// Ports: clock/reset (async, active-high); rx_data/rx_valid/rx_ready byte stream in;
//        mem_addr/mem_wdata/mem_wr memory write port; cpu_reset/load_done/error status; word_count words written.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int MAX_WORDS = 64,
  parameter int RELEASE_DELAY = 4,
  localparam int W = $clog2(MAX_WORDS + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         mem_wr,
  output logic         cpu_reset,
  output logic         load_done,
  output logic         error,
  output logic [W-1:0] word_count
);
  localparam int RW = $clog2(RELEASE_DELAY + 1);
  typedef enum logic [2:0] {S_HDR, S_COLLECT, S_WRITE, S_RELEASE, S_DONE, S_ERROR} state_t;
  state_t state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [23:0] part_q, part_d;
  logic [7:0] len_q, len_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [W-1:0] wc_q, wc_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic wr_q, wr_d, cpu_reset_q, cpu_reset_d, load_done_q, load_done_d, error_q, error_d;
  logic accept;
  assign rx_ready = (state_q == S_HDR || state_q == S_COLLECT) && !reset;
  assign accept = rx_valid && rx_ready;
  // Bytes arrive LSB first, so shifting in from the top leaves {b2,b1,b0} after three accepts.
  always_comb begin
    state_d = state_q;
    byte_idx_d = byte_idx_q;
    part_d = part_q;
    len_d = len_q;
    cnt_d = cnt_q;
    wc_d = wc_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_HDR: if (accept) begin
        len_d = rx_data;
        cnt_d = RW'(RELEASE_DELAY);
        state_d = rx_data == 8'd0 ? S_RELEASE : 32'(rx_data) > MAX_WORDS ? S_ERROR : S_COLLECT;
      end
      S_COLLECT: if (accept) begin
        byte_idx_d = byte_idx_q + 2'd1;
        part_d = {rx_data, part_q[23:8]};
        if (byte_idx_q == 2'd3) begin
          state_d = S_WRITE;
          addr_d = BASE_ADDR + 32'({wc_q, 2'b00});
          wdata_d = {rx_data, part_q};
        end
      end
      S_WRITE: begin
        wc_d = wc_q + 1'b1;
        cnt_d = RW'(RELEASE_DELAY);
        state_d = 32'(wc_d) == 32'(len_q) ? S_RELEASE : S_COLLECT;
      end
      S_RELEASE: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_DONE : S_RELEASE;
      end
      default: ;
    endcase
    wr_d = state_d == S_WRITE;
    cpu_reset_d = state_d != S_DONE;
    load_done_d = state_d == S_DONE;
    error_d = state_d == S_ERROR;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_HDR;
      byte_idx_q <= '0;
      part_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      wc_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      part_q <= part_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      wc_q <= wc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      error_q <= error_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr = wr_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign error = error_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed tests for boot_loader
module tb_boot_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, mem_wr, cpu_reset, load_done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0] word_count;
  int checks = 0;
  int fails = 0;
  int wr_cnt = 0;
  int bad_wr = 0;
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  always #5 clock = ~clock;
  boot_loader dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .cpu_reset(cpu_reset),
    .load_done(load_done), .error(error), .word_count(word_count)
  );
  always @(negedge clock) begin
    if (mem_wr) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
      if (!cpu_reset) bad_wr++;
    end
  end
  task automatic reset_dut();
    reset = 1'b1;
    #2;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = rx_ready;
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (!acc) begin fails++; $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b want 1", b, rx_ready); end
  endtask
  task automatic test_reset();
    @(posedge clock);
    #1;
    checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    checks++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (word_count !== 7'd0) begin fails++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL post_reset_rx_ready: got %b want 1", rx_ready); end
  endtask
  task automatic test_single_word();
    int base;
    logic exp;
    base = wr_cnt;
    reset_dut();
    send_byte(8'h01);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    checks++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL single_mem_wr: got %b want 1", mem_wr); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL single_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h want deadbeef", mem_wdata); end
    checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL single_write_rx_ready: got %b want 0", rx_ready); end
    @(posedge clock);
    #1;
    checks++; if (word_count !== 7'd1) begin fails++; $display("FAIL single_word_count: got %0d want 1", word_count); end
    checks++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL single_wr_pulse: got %b want 0", mem_wr); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      exp = k < 5;
      checks++; if (cpu_reset !== exp) begin fails++; $display("FAIL single_release_%0d: cpu_reset got %b want %b", k, cpu_reset, exp); end
    end
    checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL single_load_done: got %b want 1", load_done); end
    checks++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL single_write_count: got %0d want 1", wr_cnt - base); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data_hold: got %h want deadbeef", mem_wdata); end
  endtask
  task automatic test_back_to_back();
    int base;
    logic [7:0] img [13];
    logic [31:0] exp_d [3];
    img = '{8'h03, 8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hFF, 8'h00, 8'hFF, 8'h00};
    exp_d = '{32'h11223344, 32'hA5A55A5A, 32'h00FF00FF};
    base = wr_cnt;
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      send_byte(img[i]);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
    end
    for (int i = 0; i < 40 && !load_done; i++) begin
      @(posedge clock);
      #1;
    end
    checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL gaps_load_done: got %b want 1", load_done); end
    checks++; if (wr_cnt - base !== 3) begin fails++; $display("FAIL gaps_write_count: got %0d want 3", wr_cnt - base); end
    checks++; if (word_count !== 7'd3) begin fails++; $display("FAIL gaps_word_count: got %0d want 3", word_count); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (wr_addr[base + j] !== 32'(4 * j)) begin fails++; $display("FAIL gaps_addr_%0d: got %h want %h", j, wr_addr[base + j], 4 * j); end
      checks++; if (wr_data[base + j] !== exp_d[j]) begin fails++; $display("FAIL gaps_data_%0d: got %h want %h", j, wr_data[base + j], exp_d[j]); end
    end
  endtask
  task automatic test_zero_len();
    int base;
    logic exp;
    base = wr_cnt;
    reset_dut();
    send_byte(8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      exp = k < 5;
      checks++; if (cpu_reset !== exp) begin fails++; $display("FAIL zero_cpu_reset_%0d: got %b want %b", k, cpu_reset, exp); end
      checks++; if (load_done !== !exp) begin fails++; $display("FAIL zero_load_done_%0d: got %b want %b", k, load_done, !exp); end
    end
    checks++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_cnt - base); end
  endtask
  task automatic test_error();
    int base;
    int bad;
    base = wr_cnt;
    reset_dut();
    send_byte(8'h41);
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL err_flag: got %b want 1", error); end
    checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL err_rx_ready: got %b want 0", rx_ready); end
    bad = 0;
    rx_data = 8'h55;
    rx_valid = 1'b1;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (cpu_reset !== 1'b1 || rx_ready !== 1'b0 || error !== 1'b1 || mem_wr !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    checks++; if (bad !== 0) begin fails++; $display("FAIL err_hold: %0d bad cycles want 0", bad); end
    checks++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL err_writes: got %0d want 0", wr_cnt - base); end
    reset_dut();
    send_byte(8'h40);
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL max_len_error: got %b want 0", error); end
    checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL max_len_rx_ready: got %b want 1", rx_ready); end
  endtask
  task automatic test_reset_midload();
    int base;
    reset_dut();
    base = wr_cnt;
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    #1;
    checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_rx_ready: got %b want 0", rx_ready); end
    checks++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL mid_rst_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (word_count !== 7'd0) begin fails++; $display("FAIL mid_rst_word_count: got %0d want 0", word_count); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    for (int i = 0; i < 20 && !load_done; i++) begin
      @(posedge clock);
      #1;
    end
    checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL mid_load_done: got %b want 1", load_done); end
    checks++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL mid_write_count: got %0d want 1", wr_cnt - base); end
    checks++; if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL mid_addr: got %h want 0", wr_addr[base]); end
    checks++; if (wr_data[base] !== 32'h12345678) begin fails++; $display("FAIL mid_data: got %h want 12345678", wr_data[base]); end
  endtask
  task automatic test_done_ignore();
    int base;
    int bad;
    base = wr_cnt;
    bad = 0;
    rx_data = 8'hC3;
    rx_valid = 1'b1;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (rx_ready !== 1'b0 || mem_wr !== 1'b0 || cpu_reset !== 1'b0 || load_done !== 1'b1) bad++;
    end
    rx_valid = 1'b0;
    checks++; if (bad !== 0) begin fails++; $display("FAIL done_hold: %0d bad cycles want 0", bad); end
    checks++; if (word_count !== 7'd1) begin fails++; $display("FAIL done_word_count: got %0d want 1", word_count); end
    checks++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL done_writes: got %0d want 0", wr_cnt - base); end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_zero_len();
    test_error();
    test_reset_midload();
    test_done_ignore();
    checks++; if (bad_wr !== 0) begin fails++; $display("FAIL wr_while_running: got %0d want 0", bad_wr); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
